// File: rtl/pc_sequencer.sv
// Program-counter unit for the fetch stage: sequential stepping, branch/trap redirects,
// stall hold and a small circular return-address stack with misaligned-target flagging.
module pc_sequencer #(
    parameter int               XLEN         = 32,
    parameter int               STEP         = 4,
    parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
    parameter logic [XLEN-1:0]  TRAP_VECTOR  = 'h100,
    parameter int               RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            trap,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    input  logic            call,
    input  logic            ret,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] npc,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            misaligned
);

    localparam int              PW       = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int              CW       = $clog2(RAS_DEPTH + 1);
    localparam logic [XLEN-1:0] STEP_V   = XLEN'(STEP);
    localparam logic [XLEN-1:0] LOW_MASK = XLEN'(STEP - 1);
    localparam logic [PW-1:0]   PTR_MAX  = PW'(RAS_DEPTH - 1);
    localparam logic [CW-1:0]   CNT_MAX  = CW'(RAS_DEPTH);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_nxt;
    logic            mis_q;
    logic            mis_nxt;

    logic [XLEN-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]   ras_ptr;
    logic [CW-1:0]   ras_cnt;
    logic [PW-1:0]   ptr_inc;
    logic [PW-1:0]   ptr_dec;
    logic [XLEN-1:0] ras_top;

    logic            do_push;
    logic            do_pop;
    logic            do_replace;
    logic            tgt_mis;
    logic [XLEN-1:0] tgt_aligned;
    logic            call_br;

    assign npc         = pc_q + STEP_V;
    assign pc          = pc_q;
    assign misaligned  = mis_q;
    assign ras_empty   = (ras_cnt == '0);
    assign ras_full    = (ras_cnt == CNT_MAX);
    assign ras_top     = ras_mem[ras_ptr];
    assign ptr_inc     = (ras_ptr == PTR_MAX) ? '0 : ras_ptr + PW'(1);
    assign ptr_dec     = (ras_ptr == '0) ? PTR_MAX : ras_ptr - PW'(1);
    assign tgt_mis     = |(br_target & LOW_MASK);
    assign tgt_aligned = br_target & ~LOW_MASK;
    assign call_br     = call & br_taken;

    // ret wins the redirect over a same-cycle call; with a non-empty stack the
    // call then rewrites the top entry instead of pushing.
    always_comb begin
        pc_nxt     = npc;
        mis_nxt    = 1'b0;
        do_push    = 1'b0;
        do_pop     = 1'b0;
        do_replace = 1'b0;
        if (trap) begin
            pc_nxt = TRAP_VECTOR;
        end else if (stall) begin
            pc_nxt = pc_q;
        end else if (ret && !ras_empty) begin
            pc_nxt = ras_top;
            if (call_br) do_replace = 1'b1;
            else         do_pop     = 1'b1;
        end else if (ret || br_taken) begin
            pc_nxt  = tgt_aligned;
            mis_nxt = tgt_mis;
            do_push = call_br;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_VECTOR;
            mis_q   <= 1'b0;
            ras_ptr <= '0;
            ras_cnt <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
        end else begin
            pc_q  <= pc_nxt;
            mis_q <= mis_nxt;
            if (do_push) begin
                // Full stack: the pointer advances onto the oldest slot and overwrites it.
                ras_mem[ptr_inc] <= npc;
                ras_ptr          <= ptr_inc;
                if (ras_cnt != CNT_MAX) ras_cnt <= ras_cnt + CW'(1);
            end else if (do_pop) begin
                ras_ptr <= ptr_dec;
                ras_cnt <= ras_cnt - CW'(1);
            end else if (do_replace) begin
                ras_mem[ras_ptr] <= npc;
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_pc_sequencer;

    localparam int          XLEN  = 32;
    localparam int          STEP  = 4;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RV    = 32'h0;
    localparam logic [31:0] TV    = 32'h100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0, trap = 1'b0, br_taken = 1'b0, call = 1'b0, ret = 1'b0;
    logic [31:0] br_target = '0;
    logic [31:0] pc, npc;
    logic        ras_empty, ras_full, misaligned;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_pc;
    logic        m_mis;
    logic [31:0] m_ras[$];

    pc_sequencer #(
        .XLEN(XLEN), .STEP(STEP), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .RAS_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .trap(trap), .br_taken(br_taken),
        .br_target(br_target), .call(call), .ret(ret), .pc(pc), .npc(npc),
        .ras_empty(ras_empty), .ras_full(ras_full), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic t, input logic s, input logic b, input logic [31:0] tgt,
                         input logic c, input logic r);
        trap = t; stall = s; br_taken = b; br_target = tgt; call = c; ret = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 32'h0, 0, 0);
        rst_n = 1'b0;
        #3;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] exp_pc;
        drive(0, 0, 0, 32'h0, 0, 0);
        rst_n = 1'b0;
        #12;
        checks++;
        if (pc !== RV) begin errors++; $display("FAIL reset_pc got %h want %h", pc, RV); end
        checks++;
        if (ras_empty !== 1'b1 || ras_full !== 1'b0 || misaligned !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got e=%b f=%b m=%b want 1 0 0", ras_empty, ras_full, misaligned);
        end
        checks++;
        if (npc !== 32'h4) begin errors++; $display("FAIL reset_npc got %h want 00000004", npc); end
        @(negedge clk);
        rst_n = 1'b1;
        exp_pc = 32'h0;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_pc += 32'h4;
            checks++;
            if (pc !== exp_pc || ras_empty !== 1'b1) begin
                errors++;
                $display("FAIL idle_step%0d got pc=%h e=%b want pc=%h e=1", i, pc, ras_empty, exp_pc);
            end
        end
    endtask

    task automatic test_wrap();
        drive(0, 0, 1, 32'hFFFF_FFFC, 0, 0);
        tick();
        checks++;
        if (pc !== 32'hFFFF_FFFC || npc !== 32'h0) begin
            errors++;
            $display("FAIL wrap_npc got pc=%h npc=%h want fffffffc 00000000", pc, npc);
        end
        drive(0, 0, 0, 32'h0, 0, 0);
        tick();
        checks++;
        if (pc !== 32'h0 || misaligned !== 1'b0) begin
            errors++;
            $display("FAIL wrap_pc got pc=%h m=%b want 00000000 0", pc, misaligned);
        end
    endtask

    task automatic test_call_ret();
        do_reset();
        drive(0, 0, 1, 32'h10, 0, 0);
        tick();
        drive(0, 0, 1, 32'h200, 1, 0);
        tick();
        checks++;
        if (pc !== 32'h200 || ras_empty !== 1'b0) begin
            errors++;
            $display("FAIL call_pc got pc=%h e=%b want 00000200 0", pc, ras_empty);
        end
        drive(0, 0, 0, 32'h0, 0, 1);
        tick();
        checks++;
        if (pc !== 32'h14 || ras_empty !== 1'b1) begin
            errors++;
            $display("FAIL ret_pc got pc=%h e=%b want 00000014 1", pc, ras_empty);
        end
    endtask

    task automatic test_ras_overflow();
        logic [31:0] exp_ret[5];
        exp_ret = '{32'h404, 32'h304, 32'h204, 32'h104, 32'h2000};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 32'(i * 32'h100), 0, 0);
            tick();
            drive(0, 0, 1, 32'h1000, 1, 0);
            tick();
        end
        checks++;
        if (ras_full !== 1'b1 || ras_empty !== 1'b0) begin
            errors++;
            $display("FAIL ras_full got f=%b e=%b want 1 0", ras_full, ras_empty);
        end
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 32'h2000, 0, 1);
            tick();
            checks++;
            if (pc !== exp_ret[i]) begin
                errors++;
                $display("FAIL ras_ret%0d got %h want %h", i, pc, exp_ret[i]);
            end
        end
        checks++;
        if (ras_empty !== 1'b1 || ras_full !== 1'b0) begin
            errors++;
            $display("FAIL ras_drained got e=%b f=%b want 1 0", ras_empty, ras_full);
        end
    endtask

    task automatic test_stall_trap();
        do_reset();
        drive(0, 0, 1, 32'h300, 1, 0);
        tick();
        drive(0, 1, 1, 32'h500, 0, 0);
        tick();
        checks++;
        if (pc !== 32'h300 || misaligned !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold got pc=%h m=%b want 00000300 0", pc, misaligned);
        end
        drive(1, 1, 0, 32'h700, 0, 1);
        tick();
        checks++;
        if (pc !== TV || ras_empty !== 1'b0) begin
            errors++;
            $display("FAIL trap_pc got pc=%h e=%b want 00000100 0", pc, ras_empty);
        end
        drive(0, 0, 0, 32'h900, 0, 1);
        tick();
        checks++;
        if (pc !== 32'h4 || ras_empty !== 1'b1) begin
            errors++;
            $display("FAIL trap_ras_kept got pc=%h e=%b want 00000004 1", pc, ras_empty);
        end
    endtask

    task automatic test_misaligned();
        drive(0, 0, 1, 32'h203, 0, 0);
        tick();
        checks++;
        if (pc !== 32'h200 || misaligned !== 1'b1) begin
            errors++;
            $display("FAIL mis_branch got pc=%h m=%b want 00000200 1", pc, misaligned);
        end
        drive(0, 0, 0, 32'h0, 0, 0);
        tick();
        checks++;
        if (pc !== 32'h204 || misaligned !== 1'b0) begin
            errors++;
            $display("FAIL mis_pulse got pc=%h m=%b want 00000204 0", pc, misaligned);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (pc !== RV || misaligned !== 1'b0 || ras_empty !== 1'b1) begin
            errors++;
            $display("FAIL async_reset got pc=%h m=%b e=%b want %h 0 1", pc, misaligned, ras_empty, RV);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reference model: next PC from the priority rules, stack as a bounded queue.
    task automatic model_edge();
        logic [31:0] nxt;
        logic [31:0] seq;
        seq = m_pc + 32'(STEP);
        nxt = seq;
        if (trap) begin
            nxt = TV;
            m_mis = 1'b0;
        end else if (stall) begin
            nxt = m_pc;
            m_mis = 1'b0;
        end else if (ret && m_ras.size() > 0) begin
            nxt = m_ras[$];
            if (call && br_taken) m_ras[m_ras.size() - 1] = seq;
            else void'(m_ras.pop_back());
            m_mis = 1'b0;
        end else if (ret || br_taken) begin
            nxt = br_target - (br_target % 32'(STEP));
            m_mis = (br_target % 32'(STEP)) != 0;
            if (call && br_taken) begin
                m_ras.push_back(seq);
                if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            end
        end else begin
            m_mis = 1'b0;
        end
        m_pc = nxt;
    endtask

    task automatic test_random();
        logic [31:0] tgt;
        do_reset();
        m_pc = RV;
        m_mis = 1'b0;
        m_ras.delete();
        for (int i = 0; i < 400; i++) begin
            tgt = $urandom;
            if ($urandom_range(0, 1) == 0) tgt &= ~32'h3;
            drive($urandom_range(0, 19) == 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 2) == 0, tgt,
                  $urandom_range(0, 1) == 0, $urandom_range(0, 3) == 0);
            model_edge();
            tick();
            checks++;
            if (pc !== m_pc || npc !== m_pc + 32'(STEP) || misaligned !== m_mis ||
                ras_empty !== (m_ras.size() == 0) || ras_full !== (m_ras.size() == DEPTH)) begin
                errors++;
                $display("FAIL rand%0d got pc=%h npc=%h m=%b e=%b f=%b want pc=%h m=%b depth=%0d",
                         i, pc, npc, misaligned, ras_empty, ras_full, m_pc, m_mis, m_ras.size());
            end
        end
        drive(0, 0, 0, 32'h0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_call_ret();
        test_ras_overflow();
        test_stall_trap();
        test_misaligned();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
